// File: rtl/tree_upport_pkg.sv
// Shared types and width helpers for the tree router up-port allocator.
// Optional statistics counters are enabled with TREE_UPPORT_STATS_EN.
package tree_upport_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << r) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int dsp_w(input int k);
    return log2(k + 1);
  endfunction

  function automatic int cr_w(input int c);
    return log2(c + 1);
  endfunction

  function automatic int up_port(input int k);
    return k;
  endfunction

endpackage

// File: rtl/tree_upport_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the
// pointer, wrapping from K-1 back to 0.
module tree_upport_rr_arbiter
  import tree_upport_pkg::*;
#(
  parameter int K = 2
) (
  input  logic [K-1:0]         req_i,
  input  logic [log2(K)-1:0]   ptr_i,
  output logic [K-1:0]         gnt_o
);

  int   w_idx;
  logic w_found;

  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < K; i++) begin
      w_idx = int'(ptr_i) + i;
      if (w_idx >= K) w_idx = w_idx - K;
      if (!w_found && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_upport_allocator.sv
// Packet-granular round-robin owner of a tree router's up port with
// parent credit tracking; TREE_UPPORT_STATS_EN adds packet/stall counters.
module tree_upport_allocator
  import tree_upport_pkg::*;
#(
  parameter int K          = 2,
  parameter int CREDIT_NUM = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [K:0]                       flit_valid_i,
  input  logic [(K+1)*dsp_w(K)-1:0]        destport_encoded_i,
  input  logic [K:0]                       head_i,
  input  logic [K:0]                       tail_i,
  input  logic                             credit_in_i,
  output logic [K:0]                       grant_o,
  output logic                             up_send_o,
  output logic [cr_w(CREDIT_NUM)-1:0]      credit_cnt_o,
  output logic                             busy_o
`ifdef TREE_UPPORT_STATS_EN
  ,
  output logic [31:0]                      up_pkt_cnt_o,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int DSPw = dsp_w(K);
  localparam int CRw  = cr_w(CREDIT_NUM);
  localparam int PTRw = log2(K);
  localparam logic [CRw-1:0] CR_MAX = CRw'(CREDIT_NUM);

  state_t          r_state, w_state_n;
  logic [PTRw-1:0] r_owner, w_owner_n;
  logic [PTRw-1:0] r_ptr,   w_ptr_n;
  logic [CRw-1:0]  r_cnt;
  logic [CRw:0]    w_cnt_sum;
  logic [K-1:0]    w_req, w_gnt;
  logic [PTRw-1:0] w_gidx;
  logic            w_has_cr, w_send, w_tail_send;

  function automatic logic [PTRw-1:0] nxt(input logic [PTRw-1:0] i);
    return (int'(i) == K - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    w_req = '0;
    for (int j = 0; j < K; j++) begin
      w_req[j] = flit_valid_i[j] & head_i[j] &
        (destport_encoded_i[j*DSPw +: DSPw] == DSPw'(up_port(K)));
    end
  end

  tree_upport_rr_arbiter #(.K(K)) u_arb (
    .req_i (w_req),
    .ptr_i (r_ptr),
    .gnt_o (w_gnt)
  );

  always_comb begin
    w_gidx = '0;
    for (int j = 0; j < K; j++) begin
      if (w_gnt[j]) w_gidx = PTRw'(j);
    end
  end

  assign w_has_cr = (r_cnt != '0);

  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_ptr_n     = r_ptr;
    grant_o     = '0;
    w_send      = 1'b0;
    w_tail_send = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_has_cr && (|w_req)) begin
          grant_o[K-1:0] = w_gnt;
          w_send         = 1'b1;
          if (tail_i[w_gidx]) begin
            w_tail_send = 1'b1;
            w_ptr_n     = nxt(w_gidx);
          end else begin
            w_owner_n = w_gidx;
            w_state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        grant_o[r_owner] = 1'b1;
        w_send = flit_valid_i[r_owner] & w_has_cr;
        if (w_send && tail_i[r_owner]) begin
          w_tail_send = 1'b1;
          w_ptr_n     = nxt(r_owner);
          w_state_n   = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // A send only happens with a credit in hand, so this never underflows.
  always_comb begin
    w_cnt_sum = {1'b0, r_cnt} - {{CRw{1'b0}}, w_send}
              + {{CRw{1'b0}}, credit_in_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= CR_MAX;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= (w_cnt_sum > {1'b0, CR_MAX}) ? CR_MAX
                                              : w_cnt_sum[CRw-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(r_state == LOCKED && flit_valid_i[r_owner] &&
                head_i[r_owner]));
      assert (!(credit_in_i && !w_send && r_cnt == CR_MAX));
    end
  end

  assign up_send_o    = w_send;
  assign credit_cnt_o = r_cnt;
  assign busy_o       = (r_state == LOCKED);

`ifdef TREE_UPPORT_STATS_EN
  logic [31:0] r_pkt_cnt, r_stall_cnt;
  logic        w_stall;

  assign w_stall = !w_has_cr &&
    ((r_state == IDLE) ? (|w_req) : flit_valid_i[r_owner]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_tail_send) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign up_pkt_cnt_o = r_pkt_cnt;
  assign stall_cnt_o  = r_stall_cnt;
`else
  logic w_unused_tail;
  assign w_unused_tail = w_tail_send;
`endif

endmodule

// File: tb/tb_tree_upport_allocator.sv
// Scoreboard bench for tree_upport_allocator (K=2, CREDIT_NUM=4):
// per-cycle expectations are queued at drive time and popped at sample.
module tb_tree_upport_allocator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] flit_valid_i = '0;
  logic [5:0] destport_encoded_i = '0;
  logic [2:0] head_i = '0;
  logic [2:0] tail_i = '0;
  logic       credit_in_i = 1'b0;
  logic [2:0] grant_o;
  logic       up_send_o;
  logic [2:0] credit_cnt_o;
  logic       busy_o;

  typedef struct {
    logic [2:0] g;
    logic       s;
    logic [2:0] c;
    logic       b;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  tree_upport_allocator #(.K(2), .CREDIT_NUM(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .flit_valid_i       (flit_valid_i),
    .destport_encoded_i (destport_encoded_i),
    .head_i             (head_i),
    .tail_i             (tail_i),
    .credit_in_i        (credit_in_i),
    .grant_o            (grant_o),
    .up_send_o          (up_send_o),
    .credit_cnt_o       (credit_cnt_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive, queue the expectation, sample mid-cycle.
  task automatic cyc(input logic [2:0] v, input logic [5:0] d,
                     input logic [2:0] h, input logic [2:0] t,
                     input logic cr, input logic [2:0] eg,
                     input logic es, input logic [2:0] ec,
                     input logic eb, input string nm);
    exp_t e;
    exp_t o;
    @(posedge clk);
    #1;
    flit_valid_i       = v;
    destport_encoded_i = d;
    head_i             = h;
    tail_i             = t;
    credit_in_i        = cr;
    e.g = eg; e.s = es; e.c = ec; e.b = eb; e.nm = nm;
    q.push_back(e);
    #2;
    o = q.pop_front();
    n_chk++;
    if (grant_o !== o.g) begin
      n_fail++;
      $display("FAIL %s grant_o got %b expected %b", o.nm, grant_o, o.g);
    end
    n_chk++;
    if (up_send_o !== o.s) begin
      n_fail++;
      $display("FAIL %s up_send_o got %b expected %b", o.nm, up_send_o, o.s);
    end
    n_chk++;
    if (credit_cnt_o !== o.c) begin
      n_fail++;
      $display("FAIL %s credit_cnt_o got %0d expected %0d",
               o.nm, credit_cnt_o, o.c);
    end
    n_chk++;
    if (busy_o !== o.b) begin
      n_fail++;
      $display("FAIL %s busy_o got %b expected %b", o.nm, busy_o, o.b);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset              = 1'b1;
    flit_valid_i       = '0;
    destport_encoded_i = '0;
    head_i             = '0;
    tail_i             = '0;
    credit_in_i        = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(3'b000, 6'b000000, 3'b000, 3'b000, 1'b0,
        3'b000, 1'b0, 3'd4, 1'b0, "reset_idle0");
    cyc(3'b000, 6'b000000, 3'b000, 3'b000, 1'b0,
        3'b000, 1'b0, 3'd4, 1'b0, "reset_idle1");
  endtask

  task automatic test_two_packets();
    do_reset();
    cyc(3'b011, 6'b001010, 3'b011, 3'b000, 1'b0,
        3'b001, 1'b1, 3'd4, 1'b0, "pk_p0_head");
    cyc(3'b011, 6'b001010, 3'b010, 3'b000, 1'b0,
        3'b001, 1'b1, 3'd3, 1'b1, "pk_p0_body");
    cyc(3'b011, 6'b001010, 3'b010, 3'b001, 1'b0,
        3'b001, 1'b1, 3'd2, 1'b1, "pk_p0_tail");
    cyc(3'b010, 6'b001010, 3'b010, 3'b000, 1'b0,
        3'b010, 1'b1, 3'd1, 1'b0, "pk_p1_head");
    cyc(3'b010, 6'b001010, 3'b000, 3'b000, 1'b1,
        3'b010, 1'b0, 3'd0, 1'b1, "pk_p1_nocred");
    cyc(3'b010, 6'b001010, 3'b000, 3'b000, 1'b1,
        3'b010, 1'b1, 3'd1, 1'b1, "pk_p1_body");
    cyc(3'b010, 6'b001010, 3'b000, 3'b010, 1'b1,
        3'b010, 1'b1, 3'd1, 1'b1, "pk_p1_tail");
    cyc(3'b000, 6'b000000, 3'b000, 3'b000, 1'b0,
        3'b000, 1'b0, 3'd1, 1'b0, "pk_idle");
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(3'b001, 6'b000010, 3'b001, 3'b001, 1'b0,
          3'b001, 1'b1, 3'(4 - i), 1'b0, "cr_send");
    end
    cyc(3'b001, 6'b000010, 3'b001, 3'b001, 1'b0,
        3'b000, 1'b0, 3'd0, 1'b0, "cr_stall");
    cyc(3'b001, 6'b000010, 3'b001, 3'b001, 1'b1,
        3'b000, 1'b0, 3'd0, 1'b0, "cr_return");
    cyc(3'b001, 6'b000010, 3'b001, 3'b001, 1'b0,
        3'b001, 1'b1, 3'd1, 1'b0, "cr_release");
    cyc(3'b001, 6'b000010, 3'b001, 3'b001, 1'b0,
        3'b000, 1'b0, 3'd0, 1'b0, "cr_stall2");
  endtask

  task automatic test_bubble();
    do_reset();
    cyc(3'b010, 6'b001000, 3'b010, 3'b000, 1'b0,
        3'b010, 1'b1, 3'd4, 1'b0, "bub_p1_head");
    cyc(3'b011, 6'b001010, 3'b001, 3'b000, 1'b0,
        3'b010, 1'b1, 3'd3, 1'b1, "bub_p1_body");
    cyc(3'b001, 6'b001010, 3'b001, 3'b000, 1'b0,
        3'b010, 1'b0, 3'd2, 1'b1, "bub_gap0");
    cyc(3'b001, 6'b001010, 3'b001, 3'b000, 1'b0,
        3'b010, 1'b0, 3'd2, 1'b1, "bub_gap1");
    cyc(3'b011, 6'b001010, 3'b001, 3'b010, 1'b0,
        3'b010, 1'b1, 3'd2, 1'b1, "bub_p1_tail");
    cyc(3'b001, 6'b001010, 3'b001, 3'b001, 1'b0,
        3'b001, 1'b1, 3'd1, 1'b0, "bub_p0_single");
  endtask

  task automatic test_credit_and_reset();
    do_reset();
    cyc(3'b001, 6'b000010, 3'b001, 3'b000, 1'b0,
        3'b001, 1'b1, 3'd4, 1'b0, "cr_rst_head");
    cyc(3'b001, 6'b000010, 3'b000, 3'b000, 1'b0,
        3'b001, 1'b1, 3'd3, 1'b1, "cr_rst_body0");
    cyc(3'b001, 6'b000010, 3'b000, 3'b000, 1'b1,
        3'b001, 1'b1, 3'd2, 1'b1, "cr_rst_simul");
    cyc(3'b000, 6'b000010, 3'b000, 3'b000, 1'b0,
        3'b001, 1'b0, 3'd2, 1'b1, "cr_rst_kept");
    do_reset();
    cyc(3'b000, 6'b000000, 3'b000, 3'b000, 1'b0,
        3'b000, 1'b0, 3'd4, 1'b0, "cr_rst_after");
  endtask

  task automatic test_no_grant();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(3'b111, 6'b100100, 3'b111, 3'b111, 1'b0,
          3'b000, 1'b0, 3'd4, 1'b0, "nogrant");
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(3'b011, 6'b001010, 3'b011, 3'b011, 1'b1,
          (i % 2 == 0) ? 3'b001 : 3'b010, 1'b1, 3'd4, 1'b0, "b2b_rr");
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_two_packets();
    test_credit_exhaust();
    test_bubble();
    test_credit_and_reset();
    test_no_grant();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
